// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types and constants for the 6502-class cpu core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RST  = 2'd1,
        NMI  = 2'd2,
        IRQ  = 2'd3
    } int_kind_e;

    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        FETCH   = 2'd1,
        EXEC    = 2'd2
    } seq_state_e;

    localparam logic [15:0] c_nmi_vec = 16'hFFFA;
    localparam logic [15:0] c_rst_vec = 16'hFFFC;
    localparam logic [15:0] c_irq_vec = 16'hFFFE;

    // ALU operation select, shared by the datapath and the decoder
    localparam logic [3:0] c_alu_or  = 4'd0;
    localparam logic [3:0] c_alu_and = 4'd1;
    localparam logic [3:0] c_alu_eor = 4'd2;
    localparam logic [3:0] c_alu_adc = 4'd3;
    localparam logic [3:0] c_alu_sbc = 4'd4;
    localparam logic [3:0] c_alu_cmp = 4'd5;
    localparam logic [3:0] c_alu_asl = 4'd6;
    localparam logic [3:0] c_alu_lsr = 4'd7;
    localparam logic [3:0] c_alu_rol = 4'd8;
    localparam logic [3:0] c_alu_ror = 4'd9;

endpackage

`default_nettype wire

// File: rtl/cpu_int_arbiter.sv
// ============================================================================
// Module  : cpu_int_arbiter
// Brief   : NMI edge capture, IRQ masking and fixed-priority interrupt choice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_int_arbiter
    import cpu_pkg::*;
#(
    parameter int N_IRQ = 1,
    parameter int IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nmi,
    input  logic [N_IRQ-1:0] irq,
    input  logic             i_flag,
    input  logic             sample,
    output logic             take,
    output int_kind_e        kind,
    output logic [IW-1:0]    src
);

    logic          r_nmi_d;
    logic          r_nmi_pend;
    logic          w_nmi_edge;
    logic          w_nmi_req;
    logic          w_irq_req;
    logic [IW-1:0] w_irq_idx;

    assign w_nmi_edge = nmi & ~r_nmi_d;
    // An edge arriving on the deciding cycle is served without a detour through pend
    assign w_nmi_req  = r_nmi_pend | w_nmi_edge;
    assign w_irq_req  = (|irq) & ~i_flag;

    // Edge capture ignores ready so a pulse during a stall is still latched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nmi_d    <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_d <= nmi;
            if (sample && w_nmi_req) begin
                r_nmi_pend <= 1'b0;
            end else if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_irq_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                w_irq_idx = IW'(i);
            end
        end
    end

    always_comb begin
        take = w_nmi_req | w_irq_req;
        kind = NONE;
        src  = '0;
        if (w_nmi_req) begin
            kind = NMI;
        end else if (w_irq_req) begin
            kind = IRQ;
            src  = w_irq_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
// ============================================================================
// Module  : cpu_seq_ctrl
// Brief   : Instruction sequencer: T-state count, SYNC, IR and interrupt entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int          MAX_T      = 8,
    parameter int          RST_CYCLES = 7,
    parameter int          N_IRQ      = 1,
    parameter logic [15:0] NMI_VEC    = c_nmi_vec,
    parameter logic [15:0] RST_VEC    = c_rst_vec,
    parameter logic [15:0] IRQ_VEC    = c_irq_vec,
    localparam int         TW         = $clog2(MAX_T),
    localparam int         IW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             nmi,
    input  logic [N_IRQ-1:0] irq,
    input  logic             i_flag,
    input  logic [7:0]       ir_in,
    input  logic             last_cycle,
    output logic [TW-1:0]    t_state,
    output logic             sync,
    output logic [7:0]       ir,
    output logic             inject_brk,
    output int_kind_e        int_kind,
    output logic [IW-1:0]    irq_src,
    output logic [15:0]      vec_addr,
    output logic             t_ovf
);

    localparam logic [TW-1:0] c_t_last   = TW'(MAX_T - 1);
    localparam logic [TW-1:0] c_rst_last = TW'(RST_CYCLES - 1);

    seq_state_e    r_state,  w_state;
    logic [TW-1:0] r_t,      w_t;
    logic [7:0]    r_ir,     w_ir;
    logic          r_inject, w_inject;
    int_kind_e     r_kind,   w_kind;
    logic [IW-1:0] r_src,    w_src;
    logic          r_ovf,    w_ovf;
    logic          r_take,   w_take;

    logic          w_sample;
    logic          w_arb_take;
    int_kind_e     w_arb_kind;
    logic [IW-1:0] w_arb_src;

    cpu_int_arbiter #(
        .N_IRQ (N_IRQ),
        .IW    (IW)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .nmi    (nmi),
        .irq    (irq),
        .i_flag (i_flag),
        .sample (w_sample),
        .take   (w_arb_take),
        .kind   (w_arb_kind),
        .src    (w_arb_src)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= RST_SEQ;
            r_t      <= '0;
            r_ir     <= 8'h00;
            r_inject <= 1'b0;
            r_kind   <= RST;
            r_src    <= '0;
            r_ovf    <= 1'b0;
            r_take   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_t      <= w_t;
            r_ir     <= w_ir;
            r_inject <= w_inject;
            r_kind   <= w_kind;
            r_src    <= w_src;
            r_ovf    <= w_ovf;
            r_take   <= w_take;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_t      = r_t;
        w_ir     = r_ir;
        w_inject = r_inject;
        w_kind   = r_kind;
        w_src    = r_src;
        w_ovf    = r_ovf;
        w_take   = r_take;
        w_sample = 1'b0;
        if (ready) begin
            case (r_state)
                RST_SEQ: begin
                    if (r_t == c_rst_last) begin
                        w_state = FETCH;
                        w_t     = '0;
                        w_kind  = NONE;
                    end else begin
                        w_t = r_t + 1'b1;
                    end
                end
                FETCH: begin
                    w_state  = EXEC;
                    w_t      = TW'(1);
                    w_ir     = r_take ? 8'h00 : ir_in;
                    w_inject = r_take;
                end
                EXEC: begin
                    if (last_cycle) begin
                        w_sample = 1'b1;
                        w_state  = FETCH;
                        w_t      = '0;
                        w_take   = w_arb_take;
                        w_kind   = w_arb_kind;
                        w_src    = w_arb_src;
                    end else if (r_t == c_t_last) begin
                        // Runaway instruction: flag it and resume fetching, no interrupt entry
                        w_ovf   = 1'b1;
                        w_state = FETCH;
                        w_t     = '0;
                        w_take  = 1'b0;
                        w_kind  = NONE;
                        w_src   = '0;
                    end else begin
                        w_t = r_t + 1'b1;
                    end
                end
                default: begin
                    w_state = RST_SEQ;
                    w_t     = '0;
                end
            endcase
        end
    end

    always_comb begin
        case (r_kind)
            RST:     vec_addr = RST_VEC;
            NMI:     vec_addr = NMI_VEC;
            default: vec_addr = IRQ_VEC;
        endcase
    end

    assign t_state    = r_t;
    assign sync       = (r_state == FETCH);
    assign ir         = r_ir;
    assign inject_brk = r_inject;
    assign int_kind   = r_kind;
    assign irq_src    = r_src;
    assign t_ovf      = r_ovf;

endmodule

`default_nettype wire
